// File: rtl/btn_debounce_evt.sv
// Push-button front end: per-channel synchroniser, stable-count debouncer and
// press detector, feeding a one-deep press event register with a sticky loss flag.
module btn_debounce_evt #(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_i,
   output logic [N_BTN-1:0] btn_level_o,
   output logic [N_BTN-1:0] press_o,
   output logic             evt_valid_o,
   output logic [2:0]       evt_code_o,
   input  logic             evt_ready_i,
   output logic             evt_lost_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] sync1, sync2;
   logic [N_BTN-1:0] level_next;
   logic [CW-1:0]    cnt      [N_BTN];
   logic [CW-1:0]    cnt_next [N_BTN];

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      level_next = btn_level_o;
      for (int i = 0; i < N_BTN; i++) begin
         cnt_next[i] = '0;
         if (sync2[i] != btn_level_o[i]) begin
            if (cnt[i] == CNT_LAST) level_next[i] = sync2[i];
            else                    cnt_next[i]   = cnt[i] + 1'b1;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1       <= '0;
         sync2       <= '0;
         btn_level_o <= '0;
         press_o     <= '0;
         // NOTE: the counter array is a handful of flops, not a RAM, so resetting it is cheap and safe.
         cnt         <= '{default: '0};
      end else begin
         sync1       <= btn_i;
         sync2       <= sync1;
         btn_level_o <= level_next;
         press_o     <= level_next & ~btn_level_o;
         cnt         <= cnt_next;
      end
   end

   logic [2:0] first_idx;
   logic       extra_press;
   logic       any_press;
   logic       accept;
   logic       pending;

   always_comb begin
      first_idx = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (press_o[i]) first_idx = 3'(i);
      end
   end

   // Clearing the lowest set bit leaves only the presses that cannot be stored.
   assign extra_press = |(press_o & (press_o - N_BTN'(1)));
   assign any_press   = |press_o;
   assign accept      = evt_valid_o & evt_ready_i;
   assign pending     = evt_valid_o & ~evt_ready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid_o <= 1'b0;
         evt_code_o  <= '0;
         evt_lost_o  <= 1'b0;
      end else if (any_press) begin
         if (pending) begin
            evt_lost_o <= 1'b1;
         end else begin
            evt_valid_o <= 1'b1;
            evt_code_o  <= first_idx;
            evt_lost_o  <= (evt_lost_o & ~accept) | extra_press;
         end
      end else if (accept) begin
         evt_valid_o <= 1'b0;
         evt_lost_o  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_btn_debounce_evt.sv
// Directed bench for btn_debounce_evt with DEBOUNCE_CYCLES=8: bounce, glitch,
// simultaneous press, overflow/handshake and reset-mid-debounce scenarios.
module tb_btn_debounce_evt;

   localparam int N_BTN = 5;
   localparam int DEB   = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N_BTN-1:0] btn_i = '0;
   logic             evt_ready_i = 1'b0;
   logic [N_BTN-1:0] btn_level_o;
   logic [N_BTN-1:0] press_o;
   logic             evt_valid_o;
   logic [2:0]       evt_code_o;
   logic             evt_lost_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [N_BTN-1:0] seen;

   always #50 clk = ~clk;

   btn_debounce_evt #(.N_BTN(N_BTN), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_i       (btn_i),
      .btn_level_o (btn_level_o),
      .press_o     (press_o),
      .evt_valid_o (evt_valid_o),
      .evt_code_o  (evt_code_o),
      .evt_ready_i (evt_ready_i),
      .evt_lost_o  (evt_lost_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic watch(input int n, output logic [N_BTN-1:0] acc);
      acc = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
         acc |= press_o;
      end
   endtask

   initial begin
      // 1: outputs held at zero through reset regardless of inputs
      btn_i = 5'h1F;
      for (int k = 0; k < 4; k++) begin
         evt_ready_i = 1'($urandom_range(0, 1));
         step(1);
         check("reset_outputs", {btn_level_o, press_o, evt_valid_o, evt_code_o, evt_lost_o}, '0);
      end
      btn_i = '0;
      evt_ready_i = 1'b0;
      step(3);
      rst = 1'b0;
      step(2);
      check("post_reset_idle", {btn_level_o, press_o, evt_valid_o}, '0);

      // 2: bouncing press on channel 1, then release
      for (int k = 0; k < 7; k++) begin
         btn_i[1] = (k % 2 == 0);
         if (k < 6) step(3);
      end
      watch(9, seen);
      check("bounce_no_early_press", seen, 5'b00000);
      check("bounce_level_before", btn_level_o, 5'b00000);
      step(1);
      check("bounce_press_pulse", press_o, 5'b00010);
      check("bounce_level_up", btn_level_o, 5'b00010);
      step(1);
      check("bounce_press_single", press_o, 5'b00000);
      check("bounce_evt", {evt_valid_o, evt_code_o, evt_lost_o}, {1'b1, 3'd1, 1'b0});
      step(38);
      check("bounce_evt_held", {evt_valid_o, evt_code_o}, {1'b1, 3'd1});
      check("bounce_level_held", btn_level_o, 5'b00010);
      evt_ready_i = 1'b1;
      step(1);
      evt_ready_i = 1'b0;
      check("bounce_accept", {evt_valid_o, evt_code_o, evt_lost_o}, {1'b0, 3'd1, 1'b0});
      btn_i[1] = 1'b0;
      watch(9, seen);
      check("release_level_late", btn_level_o, 5'b00010);
      check("release_no_pulse_a", seen, 5'b00000);
      watch(1, seen);
      check("release_level_down", btn_level_o, 5'b00000);
      check("release_no_pulse_b", seen, 5'b00000);
      step(3);
      check("release_no_evt", evt_valid_o, 1'b0);

      // 3: a 7-cycle glitch is one cycle too short to be accepted
      btn_i = 5'b01000;
      step(7);
      btn_i = '0;
      watch(15, seen);
      check("glitch_no_press", seen, 5'b00000);
      check("glitch_level", btn_level_o, 5'b00000);
      check("glitch_no_evt", evt_valid_o, 1'b0);

      // 4: simultaneous presses keep the lowest index and flag the loss
      btn_i = 5'b10001;
      step(10);
      check("simul_press", press_o, 5'b10001);
      step(1);
      check("simul_evt", {evt_valid_o, evt_code_o, evt_lost_o}, {1'b1, 3'd0, 1'b1});
      evt_ready_i = 1'b1;
      step(1);
      evt_ready_i = 1'b0;
      check("simul_accept", {evt_valid_o, evt_lost_o}, 2'b00);
      btn_i = '0;
      watch(12, seen);
      check("simul_release_no_press", seen, 5'b00000);
      check("simul_release_level", btn_level_o, 5'b00000);

      // 5: overflow while pending, accept, then accept-and-load in the same cycle
      btn_i = 5'b00100;
      step(11);
      check("ovf_first", {evt_valid_o, evt_code_o, evt_lost_o}, {1'b1, 3'd2, 1'b0});
      btn_i = 5'b01100;
      step(11);
      check("ovf_dropped", {evt_valid_o, evt_code_o, evt_lost_o}, {1'b1, 3'd2, 1'b1});
      evt_ready_i = 1'b1;
      step(1);
      evt_ready_i = 1'b0;
      check("ovf_accept", {evt_valid_o, evt_code_o, evt_lost_o}, {1'b0, 3'd2, 1'b0});
      btn_i = '0;
      step(12);
      check("ovf_release", {btn_level_o, evt_valid_o}, '0);
      btn_i = 5'b00001;
      step(1);
      btn_i = 5'b10001;
      step(10);
      check("ovf_load0", {evt_valid_o, evt_code_o, evt_lost_o}, {1'b1, 3'd0, 1'b0});
      check("ovf_press4", press_o, 5'b10000);
      evt_ready_i = 1'b1;
      step(1);
      check("ovf_accept_load", {evt_valid_o, evt_code_o, evt_lost_o}, {1'b1, 3'd4, 1'b0});
      step(1);
      evt_ready_i = 1'b0;
      check("ovf_drain", {evt_valid_o, evt_code_o, evt_lost_o}, {1'b0, 3'd4, 1'b0});
      btn_i = '0;
      step(12);

      // 6: reset in the middle of a debounce restarts the full latency
      btn_i = 5'b00100;
      step(6);
      rst = 1'b1;
      #1;
      check("rst_mid_clear", {btn_level_o, press_o, evt_valid_o, evt_code_o, evt_lost_o}, '0);
      step(2);
      rst = 1'b0;
      watch(9, seen);
      check("rst_mid_no_early", seen, 5'b00000);
      step(1);
      check("rst_mid_press", press_o, 5'b00100);
      step(1);
      check("rst_mid_evt", {evt_valid_o, evt_code_o, evt_lost_o}, {1'b1, 3'd2, 1'b0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
